// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: 2-flop synchroniser, per-channel stable-time FSM,
// registered level plus one-cycle press/release/auto-repeat pulses.
module key_debounce_array #(
  parameter int CHANNELS      = 3,
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_RATE   = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] key_raw,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic [CHANNELS-1:0] key_repeat,
  output logic                any_down
);

  localparam logic [1:0] ST_UP        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_DOWN      = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] STABLE_LIM = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LIM  = CNT_WIDTH'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_LIM   = CNT_WIDTH'(REPEAT_RATE - 1);
  localparam logic [CHANNELS-1:0]  IDLE_RAW   = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CHANNELS-1:0]  sync_p0, sync_p1, n;
  logic [1:0]           state     [CHANNELS];
  logic [1:0]           state_nxt [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt       [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_nxt   [CHANNELS];
  logic [CNT_WIDTH-1:0] rpt       [CHANNELS];
  logic [CNT_WIDTH-1:0] rpt_nxt   [CHANNELS];
  logic [CHANNELS-1:0]  first, first_nxt;
  logic [CHANNELS-1:0]  level_nxt, press_nxt, release_nxt, repeat_nxt;

  // n = 1 means the synchronised key is pressed, regardless of pin polarity
  assign n = sync_p1 ^ IDLE_RAW;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_nxt[i]   = state[i];
      cnt_nxt[i]     = cnt[i];
      rpt_nxt[i]     = rpt[i];
      first_nxt[i]   = first[i];
      level_nxt[i]   = key_level[i];
      press_nxt[i]   = 1'b0;
      release_nxt[i] = 1'b0;
      repeat_nxt[i]  = 1'b0;
      case (state[i])
        ST_UP: begin
          if (n[i]) begin
            state_nxt[i] = ST_PRESS_CHK;
            cnt_nxt[i]   = '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!n[i]) begin
            state_nxt[i] = ST_UP;
          end else if (sample_en) begin
            if (cnt[i] == STABLE_LIM) begin
              state_nxt[i] = ST_DOWN;
              press_nxt[i] = 1'b1;
              level_nxt[i] = 1'b1;
              rpt_nxt[i]   = '0;
              first_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
            end
          end
        end
        ST_DOWN: begin
          if (!n[i]) begin
            state_nxt[i] = ST_REL_CHK;
            cnt_nxt[i]   = '0;
          end else if ((REPEAT_DELAY != 0) && sample_en) begin
            if (rpt[i] == (first[i] ? DELAY_LIM : RATE_LIM)) begin
              repeat_nxt[i] = 1'b1;
              rpt_nxt[i]    = '0;
              first_nxt[i]  = 1'b0;
            end else begin
              rpt_nxt[i] = rpt[i] + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          // release bounce returns to DOWN with the repeat timer untouched
          if (n[i]) begin
            state_nxt[i] = ST_DOWN;
            cnt_nxt[i]   = '0;
          end else if (sample_en) begin
            if (cnt[i] == STABLE_LIM) begin
              state_nxt[i]   = ST_UP;
              release_nxt[i] = 1'b1;
              level_nxt[i]   = 1'b0;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  // synchroniser stages _p0/_p1, then FSM and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0     <= IDLE_RAW;
      sync_p1     <= IDLE_RAW;
      first       <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_repeat  <= '0;
      any_down    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= ST_UP;
        cnt[i]   <= '0;
        rpt[i]   <= '0;
      end
    end else begin
      sync_p0     <= key_raw;
      sync_p1     <= sync_p0;
      first       <= first_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_repeat  <= repeat_nxt;
      any_down    <= |level_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        rpt[i]   <= rpt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array: expected pulse events are queued by the
// stimulus with hand-computed cycle numbers and checked by an independent monitor.
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b1;
  logic [2:0] key_raw = 3'b111;
  logic [2:0] key_level, key_press, key_release, key_repeat;
  logic       any_down;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         at;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [2:0] rpt;
  } ev_t;
  ev_t q[$];

  key_debounce_array #(
    .CHANNELS(3), .CNT_WIDTH(16), .STABLE_CYCLES(4),
    .REPEAT_DELAY(6), .REPEAT_RATE(3), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .any_down(any_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int at, input logic [2:0] prs, input logic [2:0] rel, input logic [2:0] rpt);
    ev_t e;
    e.at = at; e.prs = prs; e.rel = rel; e.rpt = rpt;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_level"}, key_level, 0);
    check({name, "_pulses"}, {key_press, key_release, key_repeat}, 0);
    check({name, "_any_down"}, any_down, 0);
  endtask

  // monitor: every pulse the DUT presents must match the head of the queue
  always @(negedge clk) begin
    ev_t e;
    while (q.size() > 0 && q[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_pulse cyc=%0d got=none expected at=%0d press=%b release=%b repeat=%b",
               cyc, q[0].at, q[0].prs, q[0].rel, q[0].rpt);
      void'(q.pop_front());
    end
    if ((key_press | key_release | key_repeat) != 3'b000) begin
      total++;
      if (q.size() == 0 || q[0].at != cyc) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b repeat=%b expected=none",
                 cyc, key_press, key_release, key_repeat);
      end else begin
        e = q.pop_front();
        if (e.prs !== key_press || e.rel !== key_release || e.rpt !== key_repeat) begin
          bad++;
          $display("FAIL pulse_value cyc=%0d got press=%b release=%b repeat=%b expected press=%b release=%b repeat=%b",
                   cyc, key_press, key_release, key_repeat, e.prs, e.rel, e.rpt);
        end
      end
    end
  end

  initial begin
    int b, d, e5, f;

    // asynchronous reset, before any clock edge
    #2 reset = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("after_reset");

    // clean press on ch0, repeats while held, then release with a glitch
    b = cyc;
    key_raw[0] = 1'b0;
    push(b + 7,  3'b001, 3'b000, 3'b000);
    push(b + 13, 3'b000, 3'b000, 3'b001);
    push(b + 16, 3'b000, 3'b000, 3'b001);
    push(b + 19, 3'b000, 3'b000, 3'b001);
    push(b + 22, 3'b000, 3'b000, 3'b001);
    push(b + 30, 3'b000, 3'b001, 3'b000);
    wait_until(b + 6);
    check("press_level_before", key_level[0], 0);
    wait_until(b + 7);
    check("press_level", key_level, 3'b001);
    check("press_any_down", any_down, 1);
    wait_until(b + 20);
    key_raw[0] = 1'b1;
    wait_until(b + 22);
    key_raw[0] = 1'b0;
    wait_until(b + 23);
    key_raw[0] = 1'b1;
    wait_until(b + 29);
    check("glitch_level_held", key_level[0], 1);
    wait_until(b + 30);
    check("release_level", key_level[0], 0);
    check("release_any_down", any_down, 0);

    // bounce on ch1 never qualifies
    wait_until(b + 40);
    for (int k = 0; k < 10; k++) begin
      key_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      key_raw[1] = 1'b1;
      @(negedge clk);
      check("bounce_level1", key_level[1], 0);
    end
    repeat (10) @(negedge clk);

    // hold ch2 for 30 clocks: press, repeat after 6 then every 3, release
    d = cyc;
    key_raw[2] = 1'b0;
    push(d + 7, 3'b100, 3'b000, 3'b000);
    for (int k = 13; k <= 31; k += 3) push(d + k, 3'b000, 3'b000, 3'b100);
    push(d + 37, 3'b000, 3'b100, 3'b000);
    wait_until(d + 7);
    check("hold_level2", key_level, 3'b100);
    wait_until(d + 30);
    key_raw[2] = 1'b1;
    wait_until(d + 45);
    check("hold_level2_after", key_level, 3'b000);

    // slow tick: sample_en on one posedge in four
    e5 = cyc;
    push(e5 + 16, 3'b010, 3'b000, 3'b000);
    push(e5 + 36, 3'b000, 3'b010, 3'b000);
    while (cyc < e5 + 40) begin
      sample_en = (((cyc + 1 - e5) % 4) == 0);
      if (cyc == e5) key_raw[1] = 1'b0;
      if (cyc == e5 + 20) key_raw[1] = 1'b1;
      if (cyc == e5 + 15) check("slow_level_before", key_level[1], 0);
      if (cyc == e5 + 16) check("slow_level", key_level[1], 1);
      if (cyc == e5 + 36) check("slow_level_release", key_level[1], 0);
      @(negedge clk);
    end
    sample_en = 1'b1;
    repeat (10) @(negedge clk);

    // reset mid-operation: ch0 DOWN, ch1 in PRESS_CHK
    f = cyc;
    key_raw[0] = 1'b0;
    push(f + 7, 3'b001, 3'b000, 3'b000);
    wait_until(f + 8);
    key_raw[1] = 1'b0;
    check("pre_reset_level", key_level, 3'b001);
    wait_until(f + 12);
    reset = 1'b0;
    key_raw = 3'b111;
    #1 check_all_zero("reset_mid");
    wait_until(f + 14);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("post_reset_quiet");

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
